// File: rtl/axi_fifo_wr_arb_if.sv
// Bundle between the write arbiter, its requesters and the downstream axi_fifo write port.
// master is the arbiter side; slave is the requester/FIFO side.
interface axi_fifo_wr_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_wvalid;
    logic [NREQ-1:0]    req_wready;
    logic [DW-1:0]      wdata;
    logic               wvalid;
    logic               wready;
    logic [IW-1:0]      wid;
    logic [IW-1:0]      grant_id;
    logic               burst_active;

    modport master (
        input  req_wdata, req_wvalid, wready,
        output req_wready, wdata, wvalid, wid, grant_id, burst_active
    );

    modport slave (
        output req_wdata, req_wvalid, wready,
        input  req_wready, wdata, wvalid, wid, grant_id, burst_active
    );
endinterface

// File: rtl/axi_fifo_wr_arb.sv
// Round-robin burst arbiter feeding axi_fifo through a one-entry output register; 2-cycle request-to-FIFO latency.
// Requester ready is the output slot being free (!wvalid || wready), so FIFO backpressure stalls the grant combinationally.
module axi_fifo_wr_arb #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    axi_fifo_wr_arb_if.master  bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            wvalid_q, wvalid_d;
    logic [IW-1:0]   wid_q, wid_d;

    logic [DW-1:0]   req_dat [NREQ];
    logic [NREQ-1:0] req_wready_c;
    logic            slot_free;
    logic            load;
    logic [IW-1:0]   next_ptr;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;
    logic            found;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_dat[i] = bus.req_wdata[i*DW +: DW];
        end

        // first valid requester at or above rr_ptr, wrapping modulo NREQ
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IW'((int'(rr_ptr_q) + i) % NREQ);
            if (!found && bus.req_wvalid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        slot_free    = !wvalid_q || bus.wready;
        next_ptr     = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
        req_wready_c = '0;
        load         = 1'b0;
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (slot_free) begin
                    req_wready_c[grant_q] = 1'b1;
                    if (bus.req_wvalid[grant_q]) begin
                        load       = 1'b1;
                        beat_cnt_d = beat_cnt_q + CW'(1);
                        if (beat_cnt_q == CW'(MAX_BURST - 1)) begin
                            state_d  = IDLE;
                            rr_ptr_d = next_ptr;
                        end
                    end else begin
                        // requester went quiet: release the channel without losing a beat
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        wdata_d  = wdata_q;
        wvalid_d = wvalid_q;
        wid_d    = wid_q;
        if (load) begin
            wdata_d  = req_dat[grant_q];
            wvalid_d = 1'b1;
            wid_d    = grant_q;
        end else if (wvalid_q && bus.wready) begin
            wvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            wdata_q    <= '0;
            wvalid_q   <= 1'b0;
            wid_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            wdata_q    <= wdata_d;
            wvalid_q   <= wvalid_d;
            wid_q      <= wid_d;
        end
    end

    assign bus.req_wready   = req_wready_c;
    assign bus.wdata        = wdata_q;
    assign bus.wvalid       = wvalid_q;
    assign bus.wid          = wid_q;
    assign bus.grant_id     = grant_q;
    assign bus.burst_active = (state_q == BURST);
endmodule
